// File: rtl/imm_extend_stage.sv
// Immediate generator for the 16-bit ISA decode path: opcode-selected field, sign/zero extension, optional branch shift.
// One-cycle latency; a one-entry output register plus a one-entry skid buffer, with in_ready dropping only once the skid is full.
module imm_extend_stage #(
  parameter int INSTR_W   = 16,
  parameter int OUT_W     = 16,
  parameter int SIGN_EXT  = 1,
  parameter int BR_SHIFT  = 0,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [INSTR_W-1:0]   in_instr,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_W-1:0]     out_imm,
  output logic [2:0]           out_type,
  output logic                 out_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  logic [2:0]       op_c;
  logic [3:0]       f4_c;
  logic [9:0]       f10_c;
  logic [OUT_W-1:0] imm_c;
  logic             err_c;

  assign op_c = in_instr[2:0];

  always_comb begin
    f4_c  = '0;
    f10_c = '0;
    err_c = 1'b0;
    case (op_c)
      3'b001, 3'b010: f4_c  = in_instr[15:12];
      3'b011, 3'b100: f4_c  = {in_instr[15], in_instr[5:3]};
      3'b101:         f10_c = in_instr[15:6];
      3'b110, 3'b111: err_c = 1'b1;
      default:        f4_c  = '0;
    endcase
    // R-type and illegal opcodes leave both fields at zero, so they extend to zero
    if (op_c == 3'b101) begin
      imm_c = OUT_W'(f10_c);
      if (SIGN_EXT != 0 && f10_c[9]) imm_c = imm_c | ~OUT_W'(10'h3FF);
    end else begin
      imm_c = OUT_W'(f4_c);
      if (SIGN_EXT != 0 && f4_c[3]) imm_c = imm_c | ~OUT_W'(4'hF);
    end
    if (BR_SHIFT != 0 && (op_c == 3'b100 || op_c == 3'b101)) imm_c = imm_c << 1;
  end

  logic                 or_vld_q, or_vld_d;
  logic [OUT_W-1:0]     or_imm_q, or_imm_d;
  logic [2:0]           or_type_q, or_type_d;
  logic                 or_err_q, or_err_d;
  logic                 sk_vld_q, sk_vld_d;
  logic [OUT_W-1:0]     sk_imm_q, sk_imm_d;
  logic [2:0]           sk_type_q, sk_type_d;
  logic                 sk_err_q, sk_err_d;
  logic                 in_rdy_q, in_rdy_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic                 acc_c, xfer_c;

  assign acc_c  = in_valid & in_rdy_q;
  assign xfer_c = or_vld_q & out_ready;

  always_comb begin
    or_vld_d  = or_vld_q;
    or_imm_d  = or_imm_q;
    or_type_d = or_type_q;
    or_err_d  = or_err_q;
    sk_vld_d  = sk_vld_q;
    sk_imm_d  = sk_imm_q;
    sk_type_d = sk_type_q;
    sk_err_d  = sk_err_q;
    err_cnt_d = err_cnt_q;
    if (flush) begin
      or_vld_d = 1'b0;
      sk_vld_d = 1'b0;
    end else begin
      if (xfer_c && or_err_q && err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
      // accept and skid-drain never coincide: in_ready is low whenever the skid holds data
      if (xfer_c && sk_vld_q) begin
        or_imm_d  = sk_imm_q;
        or_type_d = sk_type_q;
        or_err_d  = sk_err_q;
        sk_vld_d  = 1'b0;
      end else if (acc_c && (!or_vld_q || xfer_c)) begin
        or_vld_d  = 1'b1;
        or_imm_d  = imm_c;
        or_type_d = op_c;
        or_err_d  = err_c;
      end else if (acc_c) begin
        sk_vld_d  = 1'b1;
        sk_imm_d  = imm_c;
        sk_type_d = op_c;
        sk_err_d  = err_c;
      end else if (xfer_c) begin
        or_vld_d  = 1'b0;
      end
    end
    in_rdy_d = !sk_vld_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      or_vld_q  <= 1'b0;
      or_imm_q  <= '0;
      or_type_q <= '0;
      or_err_q  <= 1'b0;
      sk_vld_q  <= 1'b0;
      sk_imm_q  <= '0;
      sk_type_q <= '0;
      sk_err_q  <= 1'b0;
      in_rdy_q  <= 1'b1;
      err_cnt_q <= '0;
    end else begin
      or_vld_q  <= or_vld_d;
      or_imm_q  <= or_imm_d;
      or_type_q <= or_type_d;
      or_err_q  <= or_err_d;
      sk_vld_q  <= sk_vld_d;
      sk_imm_q  <= sk_imm_d;
      sk_type_q <= sk_type_d;
      sk_err_q  <= sk_err_d;
      in_rdy_q  <= in_rdy_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign in_ready  = in_rdy_q;
  assign out_valid = or_vld_q;
  assign out_imm   = or_imm_q;
  assign out_type  = or_type_q;
  assign out_err   = or_err_q;
  assign err_count = err_cnt_q;

endmodule

// File: tb/tb_imm_extend_stage.sv
// Bench for imm_extend_stage: three parameter variants share one stimulus stream,
// checked against a queue-based reference of the two-entry stage and an arithmetic immediate model.
module tb_imm_extend_stage;
  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, out_ready;
  logic [15:0] in_instr;
  logic        in_ready, out_valid, out_err;
  logic [15:0] out_imm;
  logic [2:0]  out_type;
  logic [7:0]  err_count;
  logic        in_ready_z, out_valid_z, out_err_z;
  logic [15:0] out_imm_z;
  logic [2:0]  out_type_z;
  logic [7:0]  err_count_z;
  logic        in_ready_s, out_valid_s, out_err_s;
  logic [15:0] out_imm_s;
  logic [2:0]  out_type_s;
  logic [7:0]  err_count_s;

  always #5 clk = ~clk;

  imm_extend_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
    .out_type(out_type), .out_err(out_err), .err_count(err_count));

  imm_extend_stage #(.SIGN_EXT(0)) dut_z (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_z),
    .in_instr(in_instr), .out_valid(out_valid_z), .out_ready(out_ready), .out_imm(out_imm_z),
    .out_type(out_type_z), .out_err(out_err_z), .err_count(err_count_z));

  imm_extend_stage #(.BR_SHIFT(1)) dut_s (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_s),
    .in_instr(in_instr), .out_valid(out_valid_s), .out_ready(out_ready), .out_imm(out_imm_s),
    .out_type(out_type_s), .out_err(out_err_s), .err_count(err_count_s));

  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] mq[$];
  logic [7:0]  err_m = 8'd0;

  // Immediate computed as a signed integer: field value, minus 2^width if negative, times 2^shift.
  function automatic logic [15:0] ref_imm(input logic [15:0] ins, input bit sext, input bit shift);
    int     w;
    longint f;
    logic [63:0] t;
    w = 0; f = 0;
    case (ins[2:0])
      3'd1, 3'd2: begin w = 4;  f = longint'(ins[15:12]); end
      3'd3, 3'd4: begin w = 4;  f = longint'({ins[15], ins[5:3]}); end
      3'd5:       begin w = 10; f = longint'(ins[15:6]); end
      default:    begin w = 0;  f = 0; end
    endcase
    if (sext && w > 0 && f >= (longint'(1) << (w - 1))) f = f - (longint'(1) << w);
    if (shift && (ins[2:0] == 3'd4 || ins[2:0] == 3'd5)) f = f * 2;
    t = f;
    return t[15:0];
  endfunction

  // Drives one cycle and advances the reference; returns to the bench 1 time unit after the edge.
  task automatic step(input logic v, input logic [15:0] ins, input logic ordy, input logic fl,
                      output logic acc, output logic xfer);
    in_valid = v; in_instr = ins; out_ready = ordy; flush = fl;
    acc  = v && (mq.size() < 2);
    xfer = (mq.size() > 0) && ordy;
    if (fl) mq.delete();
    else begin
      if (xfer) begin
        if (mq[0][2:0] >= 3'd6 && err_m != 8'hFF) err_m = err_m + 8'd1;
        void'(mq.pop_front());
      end
      if (acc) mq.push_back(ins);
    end
    @(posedge clk); #1;
  endtask

  function automatic logic [15:0] rand_instr(input int max_op);
    logic [15:0] r;
    r = 16'($urandom);
    r[2:0] = 3'($urandom_range(0, max_op));
    return r;
  endfunction

  task automatic test_reset;
    if ({out_valid, in_ready, out_err, out_type} !== {1'b0, 1'b1, 1'b0, 3'd0}) begin
      n_errors++; $display("FAIL reset_ctrl: got v/r/e/t=%b, want 0100000", {out_valid, in_ready, out_err, out_type});
    end
    n_checks++;
    if (out_imm !== 16'h0 || err_count !== 8'h0) begin
      n_errors++; $display("FAIL reset_data: got imm=%h cnt=%h, want 0000 00", out_imm, err_count);
    end
    n_checks++;
  endtask

  task automatic test_directed;
    logic [15:0] ins[5]  = '{16'hF001, 16'h8014, 16'h8005, 16'h7002, 16'h0000};
    logic [15:0] e1[5]   = '{16'hFFFF, 16'hFFFA, 16'hFE00, 16'h0007, 16'h0000};
    logic [15:0] ez[5]   = '{16'h000F, 16'h000A, 16'h0200, 16'h0007, 16'h0000};
    logic [15:0] es[5]   = '{16'hFFFF, 16'hFFF4, 16'hFC00, 16'h0007, 16'h0000};
    logic a, x;
    logic [15:0] cur;
    for (int k = 0; k < 5; k++) begin
      cur = ins[k];
      step(1'b1, cur, 1'b1, 1'b0, a, x);
      if (out_valid !== 1'b1 || out_type !== cur[2:0]) begin
        n_errors++; $display("FAIL directed_vld[%0d]: got v=%b t=%0d, want 1 %0d", k, out_valid, out_type, cur[2:0]);
      end
      n_checks++;
      if (out_imm !== e1[k] || out_imm_z !== ez[k] || out_imm_s !== es[k]) begin
        n_errors++; $display("FAIL directed_imm[%0d]: got %h/%h/%h, want %h/%h/%h", k,
                             out_imm, out_imm_z, out_imm_s, e1[k], ez[k], es[k]);
      end
      n_checks++;
    end
    step(1'b0, 16'h0, 1'b1, 1'b0, a, x);
    if (out_valid !== 1'b0) begin
      n_errors++; $display("FAIL directed_drain: got out_valid=%b, want 0", out_valid);
    end
    n_checks++;
  endtask

  task automatic test_back_to_back;
    logic a, x, ordy, prev_stall;
    logic [15:0] prev_imm, e;
    int sent = 0, got = 0, cyc = 0;
    logic [15:0] stream[8];
    for (int i = 0; i < 8; i++) stream[i] = rand_instr(5);
    prev_stall = 1'b0; prev_imm = '0;
    while (got < 8 && cyc < 100) begin
      ordy = (cyc % 4 == 0) || (cyc % 4 == 3);
      step(sent < 8, stream[sent % 8], ordy, 1'b0, a, x);
      if (a) sent++;
      if (x) got++;
      cyc++;
      if (out_valid !== (mq.size() > 0) || in_ready !== (mq.size() < 2)) begin
        n_errors++; $display("FAIL b2b_hs[%0d]: got v=%b r=%b, want %b %b", cyc, out_valid, in_ready,
                             mq.size() > 0, mq.size() < 2);
      end
      n_checks++;
      if (mq.size() > 0) begin
        e = mq[0];
        if (out_imm !== ref_imm(e, 1, 0) || out_type !== e[2:0] || out_imm_z !== ref_imm(e, 0, 0)
            || out_imm_s !== ref_imm(e, 1, 1)) begin
          n_errors++; $display("FAIL b2b_data[%0d]: got %h/%0d, want %h/%0d", cyc, out_imm, out_type,
                               ref_imm(e, 1, 0), e[2:0]);
        end
        n_checks++;
      end
      if (prev_stall) begin
        if (out_imm !== prev_imm) begin
          n_errors++; $display("FAIL b2b_stable[%0d]: got %h, want %h", cyc, out_imm, prev_imm);
        end
        n_checks++;
      end
      prev_stall = out_valid && !((cyc % 4 == 0) || (cyc % 4 == 3));
      prev_imm = out_imm;
    end
    if (got != 8) begin
      n_errors++; $display("FAIL b2b_count: got %0d delivered, want 8", got);
    end
    n_checks++;
  endtask

  task automatic test_flush;
    logic a, x;
    step(1'b1, 16'hF001, 1'b0, 1'b0, a, x);
    step(1'b1, 16'h8014, 1'b0, 1'b0, a, x);
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      n_errors++; $display("FAIL flush_full: got r=%b v=%b, want 0 1", in_ready, out_valid);
    end
    n_checks++;
    step(1'b1, 16'h7002, 1'b0, 1'b1, a, x);
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_valid_z !== 1'b0 || in_ready_s !== 1'b1) begin
      n_errors++; $display("FAIL flush_clear: got v=%b r=%b, want 0 1", out_valid, in_ready);
    end
    n_checks++;
    step(1'b1, 16'h3001, 1'b0, 1'b0, a, x);
    step(1'b1, 16'h5002, 1'b1, 1'b1, a, x);
    step(1'b0, 16'h0, 1'b1, 1'b0, a, x);
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_errors++; $display("FAIL flush_drop: got v=%b r=%b imm=%h, want 0 1", out_valid, in_ready, out_imm);
    end
    n_checks++;
  endtask

  task automatic test_random;
    logic a, x, fl;
    logic [15:0] e;
    for (int c = 0; c < 400; c++) begin
      fl = ($urandom_range(0, 19) == 0);
      step(1'($urandom), rand_instr(7), ($urandom_range(0, 2) != 0), fl, a, x);
      if (out_valid !== (mq.size() > 0) || in_ready !== (mq.size() < 2) || err_count !== err_m
          || out_valid_s !== (mq.size() > 0) || err_count_z !== err_m) begin
        n_errors++; $display("FAIL rand_hs[%0d]: got v=%b r=%b cnt=%h, want %b %b %h", c, out_valid, in_ready,
                             err_count, mq.size() > 0, mq.size() < 2, err_m);
      end
      n_checks++;
      if (mq.size() > 0) begin
        e = mq[0];
        if (out_imm !== ref_imm(e, 1, 0) || out_type !== e[2:0] || out_err !== (e[2:0] >= 3'd6)
            || out_imm_z !== ref_imm(e, 0, 0) || out_imm_s !== ref_imm(e, 1, 1)
            || out_type_s !== e[2:0] || out_err_z !== (e[2:0] >= 3'd6)) begin
          n_errors++; $display("FAIL rand_data[%0d]: got %h/%h/%h t=%0d e=%b, want %h/%h/%h t=%0d", c,
                               out_imm, out_imm_z, out_imm_s, out_type, out_err,
                               ref_imm(e, 1, 0), ref_imm(e, 0, 0), ref_imm(e, 1, 1), e[2:0]);
        end
        n_checks++;
      end
    end
    for (int c = 0; c < 3; c++) step(1'b0, 16'h0, 1'b1, 1'b0, a, x);
  endtask

  task automatic test_illegal_sat;
    logic a, x;
    for (int i = 0; i < 300; i++) begin
      step(1'b1, 16'h0007, 1'b1, 1'b0, a, x);
      if (i == 0) begin
        if (out_valid !== 1'b1 || out_err !== 1'b1 || out_imm !== 16'h0 || out_type !== 3'd7) begin
          n_errors++; $display("FAIL illegal_out: got v=%b e=%b imm=%h t=%0d, want 1 1 0000 7",
                               out_valid, out_err, out_imm, out_type);
        end
        n_checks++;
      end
      if (i == 100 || i == 254) begin
        if (err_count !== err_m) begin
          n_errors++; $display("FAIL illegal_cnt[%0d]: got %h, want %h", i, err_count, err_m);
        end
        n_checks++;
      end
    end
    step(1'b0, 16'h0, 1'b1, 1'b0, a, x);
    if (err_count !== 8'hFF || err_count_s !== 8'hFF) begin
      n_errors++; $display("FAIL illegal_sat: got %h, want ff", err_count);
    end
    n_checks++;
  endtask

  task automatic test_async_reset;
    logic a, x;
    step(1'b1, 16'hF001, 1'b0, 1'b0, a, x);
    step(1'b1, 16'h8005, 1'b0, 1'b0, a, x);
    #2 rst_n = 1'b0;
    #1;
    if ({out_valid, in_ready, out_err, out_type, out_imm, err_count} !== {1'b0, 1'b1, 1'b0, 3'd0, 16'h0, 8'h0}
        || out_valid_z !== 1'b0 || in_ready_s !== 1'b1) begin
      n_errors++; $display("FAIL arst_vals: got v=%b r=%b imm=%h cnt=%h, want 0 1 0000 00",
                           out_valid, in_ready, out_imm, err_count);
    end
    n_checks++;
    mq.delete(); err_m = 8'd0;
    #1 rst_n = 1'b1;
    step(1'b1, 16'h7002, 1'b1, 1'b0, a, x);
    if (out_valid !== 1'b1 || out_imm !== 16'h0007) begin
      n_errors++; $display("FAIL arst_resume: got v=%b imm=%h, want 1 0007", out_valid, out_imm);
    end
    n_checks++;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_instr = 16'h0;
    #12 rst_n = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_directed();
    test_back_to_back();
    test_flush();
    test_random();
    test_illegal_sat();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
